// File: rtl/irq_pkg.sv
// irq_pkg: shared types and helpers for the interrupt controller.
//   - irq_state_t : controller FSM state (IDLE / REQ / SERVICE)
//   - irq_prio_enc: lowest-index-wins priority encoder over up to MAX_IRQ lines
//   - irq_vec     : vector address = base + idx * stride (32-bit, caller truncates)
package irq_pkg;

    localparam int MAX_IRQ = 8;
    localparam int SEL_W   = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } irq_state_t;

    // Line 0 is the highest priority, so scan downward and let the lowest
    // set index overwrite the result last.
    function automatic logic [SEL_W-1:0] irq_prio_enc(input logic [MAX_IRQ-1:0] v);
        logic [SEL_W-1:0] idx;
        idx = '0;
        for (int i = MAX_IRQ - 1; i >= 0; i--) begin
            if (v[i]) idx = SEL_W'(i);
        end
        return idx;
    endfunction

    function automatic logic [31:0] irq_vec(input logic [31:0] base,
                                            input logic [31:0] stride,
                                            input logic [SEL_W-1:0] idx);
        return base + stride * {29'd0, idx};
    endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// irq_sync_edge: one interrupt line brought into the clk domain.
//   clk   in  system clock
//   reset in  asynchronous active-low reset
//   raw   in  asynchronous request line
//   evt   out edge mode: one-cycle pulse on a synchronized rising edge
//              level mode (IRQ_LEVEL_EN defined): synchronized level
// Build option: IRQ_LEVEL_EN selects level-sensitive lines (no edge flop).
module irq_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic evt
);

    logic s1, s2;

`ifdef IRQ_LEVEL_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end
    end

    assign evt = s2;
`else
    logic s3;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= raw;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign evt = s2 & ~s3;
`endif

endmodule

// File: rtl/irq_controller.sv
// irq_controller: synchronizes raw interrupt lines, latches them as pending,
// applies a software mask and fixed priority (line 0 highest), and hands one
// request at a time to the CPU through an ack / return handshake.
//   clk        in  system clock
//   reset      in  asynchronous active-low reset
//   irq_raw    in  raw asynchronous request lines (rising edge = request)
//   mask_we    in  mask register write strobe
//   mask_wdata in  new mask (1 = line blocked)
//   int_ack    in  CPU took the request (one-cycle pulse)
//   int_ret    in  CPU returned from the handler (one-cycle pulse)
//   int_req    out request to CPU
//   int_vec    out vector of the request presented / in service
//   pending    out pending bitmap, mask not applied
//   in_service out CPU is inside a handler
// Build option: IRQ_LEVEL_EN makes lines level-sensitive; pending then follows
// the synchronized line and the device must drop it to end the request.
module irq_controller
    import irq_pkg::*;
#(
    parameter int               NUM_IRQ    = 2,
    parameter int               VEC_W      = 10,
    parameter logic [VEC_W-1:0] VEC_BASE   = VEC_W'(1),
    parameter logic [VEC_W-1:0] VEC_STRIDE = VEC_W'(1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq_raw,
    input  logic               mask_we,
    input  logic [NUM_IRQ-1:0] mask_wdata,
    input  logic               int_ack,
    input  logic               int_ret,
    output logic               int_req,
    output logic [VEC_W-1:0]   int_vec,
    output logic [NUM_IRQ-1:0] pending,
    output logic               in_service
);

    logic [NUM_IRQ-1:0] evt;
    logic [NUM_IRQ-1:0] mask;
    logic [NUM_IRQ-1:0] eligible;
    logic [SEL_W-1:0]   winner;
    logic [VEC_W-1:0]   win_vec;

    irq_state_t         state, state_nx;
    logic [VEC_W-1:0]   vec_nx;

    // Per-line synchronizer / edge detector.
    for (genvar i = 0; i < NUM_IRQ; i++) begin : g_line
        irq_sync_edge u_sync (
            .clk   (clk),
            .reset (reset),
            .raw   (irq_raw[i]),
            .evt   (evt[i])
        );
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) mask <= '0;
        else if (mask_we) mask <= mask_wdata;
    end

`ifdef IRQ_LEVEL_EN
    // Pending is simply the synchronized level; ack never clears it.
    assign pending = evt;
`else
    logic [SEL_W-1:0]   sel;
    logic [NUM_IRQ-1:0] clr;

    // Line being presented/serviced; needed to clear the right pending bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) sel <= '0;
        else if (state == IDLE && |eligible) sel <= winner;
    end

    assign clr = (state == REQ && int_ack) ? (NUM_IRQ'(1) << sel) : '0;

    // Set has priority over the ack clear so a fresh edge on the line
    // being acknowledged is not lost.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) pending <= '0;
        else        pending <= (pending & ~clr) | evt;
    end
`endif

    assign eligible = pending & ~mask;
    assign winner   = irq_prio_enc(MAX_IRQ'(eligible));
    assign win_vec  = VEC_W'(irq_vec(32'(VEC_BASE), 32'(VEC_STRIDE), winner));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            int_req    <= 1'b0;
            in_service <= 1'b0;
            int_vec    <= '0;
        end else begin
            state      <= state_nx;
            int_req    <= (state_nx == REQ);
            in_service <= (state_nx == SERVICE);
            int_vec    <= vec_nx;
        end
    end

    // Mask changes only affect the selection made in IDLE; a request already
    // latched into REQ stays up until acknowledged.
    always_comb begin
        state_nx = state;
        vec_nx   = int_vec;
        case (state)
            IDLE: begin
                if (|eligible) begin
                    state_nx = REQ;
                    vec_nx   = win_vec;
                end
            end
            REQ: begin
                if (int_ack) state_nx = SERVICE;
            end
            SERVICE: begin
                if (int_ret) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_irq_controller.sv
module tb_irq_controller;

    localparam int NUM_IRQ = 2;
    localparam int VEC_W   = 10;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic [NUM_IRQ-1:0] irq_raw = '0;
    logic               mask_we = 1'b0;
    logic [NUM_IRQ-1:0] mask_wdata = '0;
    logic               int_ack = 1'b0;
    logic               int_ret = 1'b0;
    logic               int_req;
    logic [VEC_W-1:0]   int_vec;
    logic [NUM_IRQ-1:0] pending;
    logic               in_service;

    int n_vec = 0;
    int n_err = 0;
    logic [VEC_W-1:0] exp_q[$];

    irq_controller dut (
        .clk        (clk),
        .reset      (reset),
        .irq_raw    (irq_raw),
        .mask_we    (mask_we),
        .mask_wdata (mask_wdata),
        .int_ack    (int_ack),
        .int_ret    (int_ret),
        .int_req    (int_req),
        .int_vec    (int_vec),
        .pending    (pending),
        .in_service (in_service)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Bounded wait for int_req, then score the presented vector.
    task automatic expect_req(input string tag, input int max);
        int k;
        k = 0;
        while (int_req !== 1'b1 && k < max) begin
            tick();
            k++;
        end
        chk({tag, "_req"}, 32'(int_req), 32'd1);
        if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $error("FAIL %s_vec: observed %0h expected none queued", tag, int_vec);
        end else begin
            chk({tag, "_vec"}, 32'(int_vec), 32'(exp_q.pop_front()));
        end
    endtask

    task automatic ack();
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
    endtask

    task automatic ret();
        int_ret = 1'b1;
        tick();
        int_ret = 1'b0;
    endtask

    initial begin
        logic saw_req;

        // ---- reset ----
        #10000;
        chk("rst_req", 32'(int_req), 0);
        chk("rst_vec", 32'(int_vec), 0);
        chk("rst_pend", 32'(pending), 0);
        chk("rst_insvc", 32'(in_service), 0);
        @(negedge clk);
        reset = 1'b1;
        tick();
        chk("post_rst_req", 32'(int_req), 0);

        // ack in IDLE is ignored
        ack();
        chk("stray_ack", 32'(in_service), 0);

        // ---- single edge, exact latency ----
        irq_raw = 2'b01;
        exp_q.push_back(10'd1);
        ticks(3);
        chk("lat_pend", 32'(pending), 32'h1);
        chk("lat_req_early", 32'(int_req), 0);
        tick();
        expect_req("single", 0);
        // return while in REQ is ignored
        ret();
        chk("stray_ret", 32'(int_req), 1);
        ack();
        chk("single_insvc", 32'(in_service), 1);
        chk("single_reqlow", 32'(int_req), 0);
        chk("single_pend", 32'(pending), 0);
        chk("single_vechold", 32'(int_vec), 1);
        ret();
        chk("single_ret", 32'(in_service), 0);
        irq_raw = 2'b00;
        ticks(3);

        // ---- priority ----
        irq_raw = 2'b11;
        exp_q.push_back(10'd1);
        exp_q.push_back(10'd2);
        expect_req("prio0", 8);
        ack();
        chk("prio_pend_mid", 32'(pending), 32'h2);
        ret();
        expect_req("prio1", 4);
        ack();
        chk("prio_pend_end", 32'(pending), 0);
        ret();
        irq_raw = 2'b00;
        ticks(3);

        // ---- mask, with a merged second edge ----
        mask_we = 1'b1;
        mask_wdata = 2'b01;
        tick();
        mask_we = 1'b0;
        irq_raw = 2'b01;
        saw_req = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (i == 6) irq_raw = 2'b00;
            if (i == 10) irq_raw = 2'b01;
            tick();
            if (int_req) saw_req = 1'b1;
        end
        chk("mask_pend", 32'(pending), 32'h1);
        chk("mask_noreq", 32'(saw_req), 0);
        exp_q.push_back(10'd1);
        mask_we = 1'b1;
        mask_wdata = 2'b00;
        tick();
        mask_we = 1'b0;
        expect_req("unmask", 2);
        ack();
        ret();
        saw_req = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (int_req) saw_req = 1'b1;
        end
        chk("merge_single", 32'(saw_req), 0);
        irq_raw = 2'b00;
        ticks(3);

        // ---- ack / edge collision ----
        irq_raw = 2'b01;
        exp_q.push_back(10'd1);
        expect_req("coll_a", 8);
        irq_raw = 2'b00;
        ticks(3);
        irq_raw = 2'b01;
        ticks(2);          // edge pulse now high, lands with the ack
        ack();
        chk("coll_pend", 32'(pending), 32'h1);
        chk("coll_insvc", 32'(in_service), 1);
        exp_q.push_back(10'd1);
        ret();
        expect_req("coll_b", 3);
        ack();
        chk("coll_pend_end", 32'(pending), 0);
        ret();
        irq_raw = 2'b00;
        ticks(3);

        // ---- reset mid-service ----
        irq_raw = 2'b01;
        exp_q.push_back(10'd1);
        expect_req("rmid", 8);
        irq_raw = 2'b11;
        ticks(3);
        ack();
        chk("rmid_pend", 32'(pending), 32'h2);
        chk("rmid_insvc", 32'(in_service), 1);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_req", 32'(int_req), 0);
        chk("arst_vec", 32'(int_vec), 0);
        chk("arst_pend", 32'(pending), 0);
        chk("arst_insvc", 32'(in_service), 0);
        irq_raw = 2'b00;
        ticks(2);
        reset = 1'b1;
        ticks(5);
        chk("arst_after_req", 32'(int_req), 0);
        chk("arst_after_pend", 32'(pending), 0);

        chk("sb_drain", 32'(exp_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
